// File: rtl/seq_detect_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Runtime-programmable serial bit-pattern detector. A pattern of 1..MAX_LEN
// bits is matched against a qualified serial input stream. The newest bit
// lands in bit 0 of the history register, so the first pattern bit expected
// is cfg_pattern_i[len-1] and the last one is cfg_pattern_i[0]. Overlapping
// or non-overlapping matching is selectable.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst_n          asynchronous active-low reset
//   cfg_load_i     one-cycle strobe capturing pattern/length/overlap
//   cfg_pattern_i  pattern, right-aligned
//   cfg_len_i      pattern length (0 disables, >MAX_LEN is clamped)
//   cfg_overlap_i  1 = overlapping matches, 0 = restart after a match
//   cnt_clr_i      synchronous clear of the match counter
//   data_valid_i   qualifies data_i
//   data_i         serial input bit
//   match_pulse_o  one-cycle pulse per match
//   match_toggle_o inverts on every match
//   match_count_o  saturating match counter
//   len_err_o      last load had an illegal length
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int                     MAX_LEN     = 8,
    parameter int                     LEN_W       = 4,
    parameter int                     CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]     DEF_PATTERN = 8'b0000_1101,
    parameter logic [LEN_W-1:0]       DEF_LEN     = 4'd4,
    parameter logic                   DEF_OVERLAP = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_load_i,
    input  logic [MAX_LEN-1:0]   cfg_pattern_i,
    input  logic [LEN_W-1:0]     cfg_len_i,
    input  logic                 cfg_overlap_i,
    input  logic                 cnt_clr_i,
    input  logic                 data_valid_i,
    input  logic                 data_i,
    output logic                 match_pulse_o,
    output logic                 match_toggle_o,
    output logic [CNT_W-1:0]     match_count_o,
    output logic                 len_err_o
);

    localparam logic [LEN_W-1:0] MaxLenL = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               len_err_q, len_err_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               pulse_q, pulse_d;
    logic               toggle_q, toggle_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [MAX_LEN-1:0] histShift;
    logic [LEN_W-1:0]   fillInc;
    logic [MAX_LEN-1:0] lenMask;
    logic               match;

    // Candidate history/fill for a consumed bit, and a mask selecting the
    // low len_q bits so pattern bits above the active length are ignored.
    always_comb begin
        histShift = {hist_q[MAX_LEN-2:0], data_i};
        fillInc   = (fill_q == MaxLenL) ? fill_q : fill_q + 1'b1;
        lenMask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            lenMask[i] = (i < int'(len_q));
        end
    end

    // A match needs a consumed bit (a load in the same cycle discards it),
    // a non-zero length, enough fresh bits, and equality on the active bits.
    always_comb begin
        match = data_valid_i && !cfg_load_i && (len_q != '0) &&
                (fillInc >= len_q) &&
                (((histShift ^ pattern_q) & lenMask) == '0);
    end

    // Next-state logic. A configuration load restarts the history but leaves
    // the match counter and toggle alone. Without overlap the fill count is
    // dropped after a match so the next match needs len fresh bits; the
    // counter clear takes priority over a simultaneous increment.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        len_err_d = len_err_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pulse_d   = match;
        toggle_d  = toggle_q ^ match;
        count_d   = count_q;

        if (cfg_load_i) begin
            pattern_d = cfg_pattern_i;
            overlap_d = cfg_overlap_i;
            hist_d    = '0;
            fill_d    = '0;
            if (cfg_len_i == '0) begin
                len_d     = '0;
                len_err_d = 1'b1;
            end else if (cfg_len_i > MaxLenL) begin
                len_d     = MaxLenL;
                len_err_d = 1'b1;
            end else begin
                len_d     = cfg_len_i;
                len_err_d = 1'b0;
            end
        end else if (data_valid_i) begin
            hist_d = histShift;
            fill_d = (match && !overlap_q) ? '0 : fillInc;
        end

        if (cnt_clr_i) begin
            count_d = '0;
        end else if (match && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // State and registered outputs; reset restores the default pattern and
    // drops any partial match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= DEF_LEN;
            overlap_q <= DEF_OVERLAP;
            len_err_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            pulse_q   <= 1'b0;
            toggle_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            len_err_q <= len_err_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pulse_q   <= pulse_d;
            toggle_q  <= toggle_d;
            count_q   <= count_d;
        end
    end

    assign match_pulse_o  = pulse_q;
    assign match_toggle_o = toggle_q;
    assign match_count_o  = count_q;
    assign len_err_o      = len_err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//
// Directed bench for seq_detect_param. Two instances share all inputs: the
// default one (CNT_W=8) and a narrow one (CNT_W=2) for counter saturation.
// A bit-list model tracks what each output must be; it is compared against
// both instances on every falling edge, and literal expectations at the end
// of each scenario pin the model.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

    logic       clk;
    logic       rst_n;
    logic       cfgLoad;
    logic [7:0] cfgPattern;
    logic [3:0] cfgLen;
    logic       cfgOverlap;
    logic       cntClr;
    logic       dataValid;
    logic       dataBit;

    logic       pulseA, toggleA, errA;
    logic [7:0] countA;
    logic       pulseB, toggleB, errB;
    logic [1:0] countB;

    int checks = 0;
    int errors = 0;

    seq_detect_param dutA (
        .clk(clk), .rst_n(rst_n),
        .cfg_load_i(cfgLoad), .cfg_pattern_i(cfgPattern), .cfg_len_i(cfgLen),
        .cfg_overlap_i(cfgOverlap), .cnt_clr_i(cntClr),
        .data_valid_i(dataValid), .data_i(dataBit),
        .match_pulse_o(pulseA), .match_toggle_o(toggleA),
        .match_count_o(countA), .len_err_o(errA)
    );

    seq_detect_param #(.CNT_W(2)) dutB (
        .clk(clk), .rst_n(rst_n),
        .cfg_load_i(cfgLoad), .cfg_pattern_i(cfgPattern), .cfg_len_i(cfgLen),
        .cfg_overlap_i(cfgOverlap), .cnt_clr_i(cntClr),
        .data_valid_i(dataValid), .data_i(dataBit),
        .match_pulse_o(pulseB), .match_toggle_o(toggleB),
        .match_count_o(countB), .len_err_o(errB)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a list of received bits (newest at the back), the
    // number of bits received since the last load or non-overlapping match,
    // and the active configuration. A match is the last len bits equal to the
    // pattern read from bit len-1 down to bit 0.
    bit  mHist[$];
    int  mFresh;
    bit  [7:0] mPatt;
    int  mLen;
    bit  mOverlap;
    bit  expPulse, expToggle, expErr;
    int  expCountA, expCountB;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mHist.delete();
            mFresh    = 0;
            mPatt     = 8'b0000_1101;
            mLen      = 4;
            mOverlap  = 1'b0;
            expPulse  = 1'b0;
            expToggle = 1'b0;
            expErr    = 1'b0;
            expCountA = 0;
            expCountB = 0;
        end else begin
            expPulse = 1'b0;
            if (cfgLoad) begin
                mPatt    = cfgPattern;
                mOverlap = cfgOverlap;
                mHist.delete();
                mFresh   = 0;
                if (cfgLen == 0) begin
                    mLen = 0; expErr = 1'b1;
                end else if (cfgLen > 8) begin
                    mLen = 8; expErr = 1'b1;
                end else begin
                    mLen = int'(cfgLen); expErr = 1'b0;
                end
            end else if (dataValid) begin
                bit hit;
                mHist.push_back(dataBit);
                if (mHist.size() > 8) void'(mHist.pop_front());
                mFresh++;
                hit = (mLen > 0) && (mFresh >= mLen);
                for (int k = 0; k < mLen && hit; k++) begin
                    if (mHist[mHist.size() - 1 - k] != mPatt[k]) hit = 1'b0;
                end
                if (hit) begin
                    expPulse  = 1'b1;
                    expToggle = ~expToggle;
                    if (expCountA < 255) expCountA++;
                    if (expCountB < 3)   expCountB++;
                    if (!mOverlap) mFresh = 0;
                end
            end
            if (cntClr) begin
                expCountA = 0;
                expCountB = 0;
            end
        end
    end

    task automatic compareOne(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        compareOne("pulseA",  int'(pulseA),  int'(expPulse));
        compareOne("toggleA", int'(toggleA), int'(expToggle));
        compareOne("countA",  int'(countA),  expCountA);
        compareOne("lenErrA", int'(errA),    int'(expErr));
        compareOne("pulseB",  int'(pulseB),  int'(expPulse));
        compareOne("countB",  int'(countB),  expCountB);
    end

    // Literal expectation against the default instance.
    task automatic checkOutput(input string name, input int actual, input int expected);
        compareOne(name, actual, expected);
    endtask

    // One clock of stimulus; returns just after the edge so outputs are
    // already updated for that edge.
    task automatic applyStimulus(input logic load, input logic [7:0] pat, input logic [3:0] len,
                                 input logic ovl, input logic clr, input logic valid, input logic d);
        cfgLoad    = load;
        cfgPattern = pat;
        cfgLen     = len;
        cfgOverlap = ovl;
        cntClr     = clr;
        dataValid  = valid;
        dataBit    = d;
        @(posedge clk);
        #1;
        cfgLoad   = 1'b0;
        cntClr    = 1'b0;
        dataValid = 1'b0;
    endtask

    // Sends n valid bits, bits[n-1] first.
    task automatic sendBits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, bits[i]);
        end
    endtask

    task automatic loadCfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        applyStimulus(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; cfgLoad = 1'b0; cfgPattern = '0; cfgLen = '0;
        cfgOverlap = 1'b0; cntClr = 1'b0; dataValid = 1'b0; dataBit = 1'b0;
        #2;
        doReset();

        $display("[TB] scenario 1: default 1101");
        checkOutput("resetPulse",  int'(pulseA),  0);
        checkOutput("resetToggle", int'(toggleA), 0);
        checkOutput("resetCount",  int'(countA),  0);
        checkOutput("resetErr",    int'(errA),    0);
        sendBits(16'b1101, 4);
        checkOutput("t1Pulse",  int'(pulseA),  1);
        checkOutput("t1Toggle", int'(toggleA), 1);
        checkOutput("t1Count",  int'(countA),  1);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1PulseDrop", int'(pulseA), 0);

        $display("[TB] scenario 2: non-overlap");
        doReset();
        sendBits(16'b1101101, 7);
        checkOutput("t2aCount", int'(countA), 1);
        doReset();
        sendBits(16'b11011101, 8);
        checkOutput("t2bCount",  int'(countA),  2);
        checkOutput("t2bToggle", int'(toggleA), 0);

        $display("[TB] scenario 3: 101 overlap / no overlap");
        doReset();
        loadCfg(8'b101, 4'd3, 1'b1);
        sendBits(16'b10101, 5);
        checkOutput("t3aCount", int'(countA), 2);
        loadCfg(8'b101, 4'd3, 1'b0);
        sendBits(16'b10101, 5);
        checkOutput("t3bCount", int'(countA), 3);

        $display("[TB] scenario 4: gapped input");
        doReset();
        sendBits(16'b11, 2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, logic'(i % 2));
        end
        sendBits(16'b01, 2);
        checkOutput("t4Pulse", int'(pulseA), 1);
        checkOutput("t4Count", int'(countA), 1);

        $display("[TB] scenario 5: length errors and saturation");
        doReset();
        loadCfg(8'b0000_1101, 4'd0, 1'b0);
        checkOutput("t5LenZeroErr", int'(errA), 1);
        sendBits(16'b11011101, 8);
        checkOutput("t5LenZeroCount", int'(countA), 0);
        loadCfg(8'b1011_0011, 4'd12, 1'b0);
        checkOutput("t5ClampErr", int'(errA), 1);
        sendBits(16'b10110011, 8);
        checkOutput("t5ClampCount", int'(countA), 1);
        doReset();
        loadCfg(8'b1, 4'd1, 1'b1);
        checkOutput("t5LenOkErr", int'(errA), 0);
        sendBits(16'b11111, 5);
        checkOutput("t5CountWide",   int'(countA), 5);
        checkOutput("t5CountNarrow", int'(countB), 3);

        $display("[TB] scenario 6: reset mid-stream, counter clear");
        doReset();
        sendBits(16'b110, 3);
        rst_n = 1'b0;
        #1;
        checkOutput("t6RstPulse",  int'(pulseA),  0);
        checkOutput("t6RstToggle", int'(toggleA), 0);
        checkOutput("t6RstCount",  int'(countA),  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sendBits(16'b1, 1);
        checkOutput("t6NoMatch", int'(countA), 0);
        doReset();
        sendBits(16'b110, 3);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("t6ClrPulse",  int'(pulseA),  1);
        checkOutput("t6ClrCount",  int'(countA),  0);
        checkOutput("t6ClrToggle", int'(toggleA), 1);
        applyStimulus(1'b1, 8'b0000_1101, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        sendBits(16'b101, 3);
        checkOutput("t6LoadWinsCount", int'(countA), 0);
        checkOutput("t6LoadWinsPulse", int'(pulseA), 0);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
